// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: four-requester arbiter sharing one sequential double-dabble binary-to-BCD converter
module bcd_conv_arbiter #(
    parameter int BIN_W = 8,
    parameter int DIG = 3,
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         req,
    input  logic [4*BIN_W-1:0] bin_in,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_id,
    output logic [4*DIG-1:0]   bcd_out
);
    localparam int SW = DIG*4 + BIN_W;
    localparam int CW = $clog2(BIN_W + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [SW-1:0] sr, sr_n;
    logic [CW-1:0] cnt;
    logic [1:0] last_id, win, idx;
    logic last;
    assign last = cnt == CW'(BIN_W - 1);
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ROUND_ROBIN ? last_id + 2'(k) + 2'd1 : 2'(3 - k);
            win = req[idx] ? idx : win;
        end
    end
    // Digits never exceed 9 before the shift, so the add-3 cannot carry across digits.
    always_comb begin
        sr_n = sr;
        for (int d = 0; d < DIG; d++)
            sr_n[BIN_W+4*d +: 4] = sr[BIN_W+4*d +: 4] >= 4'd5 ? sr[BIN_W+4*d +: 4] + 4'd3 : sr[BIN_W+4*d +: 4];
        sr_n = {sr_n[SW-2:0], 1'b0};
    end
    always_comb begin
        state_n = state;
        busy = state != IDLE;
        done = state == DONE;
        state_n = state == IDLE ? (req != 4'd0 ? SHIFT : IDLE) : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            gnt <= '0;
            sr <= '0;
            cnt <= '0;
            last_id <= 2'd3;
            done_id <= '0;
            bcd_out <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req != 4'd0) begin
                gnt <= 4'b1 << win;
                sr <= {{(DIG*4){1'b0}}, bin_in[int'(win)*BIN_W +: BIN_W]};
                cnt <= '0;
                last_id <= win;
            end
            if (state == SHIFT) begin
                sr <= sr_n;
                cnt <= cnt + 1'b1;
                if (last) begin
                    bcd_out <= sr_n[SW-1 -: 4*DIG];
                    done_id <= last_id;
                end
            end
            if (state == DONE) gnt <= '0;
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: scoreboard bench running fixed-priority and round-robin instances side by side
module tb_bcd_conv_arbiter;
    localparam int BW = 8;
    localparam int DG = 3;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    int n_tests = 0;
    int n_fail = 0;
    logic [3:0] req [2];
    logic [4*BW-1:0] bin [2];
    logic [3:0] gnt [2];
    logic busy [2];
    logic done [2];
    logic [1:0] done_id [2];
    logic [4*DG-1:0] bcd_out [2];
    bit rand_on = 1'b0;
    logic [3:0] auto_drop = 4'hF;
    logic [1:0] glog [2][64];
    int gcnt [2];
    int pushed [2];
    int popped [2];

    task automatic check(int m, string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL m%0d %s: got %0h expected %0h at %0t", m, nm, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] pick(logic [3:0] r, logic [1:0] lst, int rr);
        if (rr != 0) begin
            for (int k = 1; k <= 4; k++) if (r[(int'(lst) + k) % 4]) return 2'((int'(lst) + k) % 4);
        end else begin
            for (int k = 3; k >= 0; k--) if (r[k]) return 2'(k);
        end
        return 2'd0;
    endfunction

    function automatic logic [4*DG-1:0] to_bcd(int v);
        logic [4*DG-1:0] r = '0;
        for (int d = 0; d < DG; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        bcd_conv_arbiter #(.BIN_W(BW), .DIG(DG), .ROUND_ROBIN(g)) dut (
            .clk(clk), .reset_n(reset_n), .req(req[g]), .bin_in(bin[g]), .gnt(gnt[g]),
            .busy(busy[g]), .done(done[g]), .done_id(done_id[g]), .bcd_out(bcd_out[g])
        );
        logic [4*DG+1:0] sb [$];
        int m_cnt = 0;
        logic [1:0] m_w = '0;
        logic [1:0] m_last = 2'd3;
        logic [4*DG-1:0] h_bcd = '0;
        logic [1:0] h_id = '0;
        logic [4*DG+1:0] e;
        logic [3:0] pg = '0;
        int s;
        // Transaction-level model: a conversion occupies BIN_W+2 edges and its result is known at grant time.
        initial forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                pushed[g] -= sb.size();
                sb.delete();
                m_cnt = 0;
                m_last = 2'd3;
            end else if (m_cnt == 0) begin
                if (req[g] != 4'd0) begin
                    m_w = pick(req[g], m_last, g);
                    m_last = m_w;
                    m_cnt = BW + 1;
                    sb.push_back({m_w, to_bcd(int'(bin[g][int'(m_w)*BW +: BW]))});
                    pushed[g]++;
                end
            end else m_cnt--;
        end
        initial forever begin
            @(negedge clk);
            check(g, "gnt", 32'(gnt[g]), m_cnt != 0 ? 32'(4'b1 << m_w) : 32'd0);
            check(g, "busy", 32'(busy[g]), 32'(m_cnt != 0));
            check(g, "done", 32'(done[g]), 32'(m_cnt == 1));
            if (!reset_n) begin
                h_bcd = '0;
                h_id = '0;
            end else if (done[g]) begin
                check(g, "sb_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    popped[g]++;
                    h_id = e[4*DG +: 2];
                    h_bcd = e[4*DG-1:0];
                end
            end
            check(g, "done_id", 32'(done_id[g]), 32'(h_id));
            check(g, "bcd_out", 32'(bcd_out[g]), 32'(h_bcd));
            if (gnt[g] != 4'd0 && pg == 4'd0 && gcnt[g] < 64) begin
                for (int k = 0; k < 4; k++) if (gnt[g][k]) glog[g][gcnt[g]] = 2'(k);
                gcnt[g]++;
            end
            pg = gnt[g];
        end
        initial forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req[g][i] && done[g] && done_id[g] == 2'(i) && auto_drop[i]) req[g][i] = 1'b0;
                else if (rand_on) begin
                    if (!req[g][i] && $urandom_range(3) == 0) req[g][i] = 1'b1;
                    else if (req[g][i] && $urandom_range(31) == 0) req[g][i] = 1'b0;
                end
            end
            if (rand_on && $urandom_range(1) == 0) begin
                s = int'($urandom_range(3));
                bin[g][s*BW +: BW] = BW'($urandom);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        gcnt[0] = 0;
        gcnt[1] = 0;
    endtask

    task automatic wait_done(int g);
        int k = 0;
        while (!done[g] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(g, "done_seen", 32'(done[g]), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((req[0] != 4'd0 || req[1] != 4'd0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(0, "drain", 32'(k < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_order(int g, string nm, int n, logic [15:0] seq);
        check(g, {nm, "_count"}, 32'(gcnt[g]), 32'(n));
        for (int k = 0; k < n; k++) check(g, nm, 32'(glog[g][k]), 32'(seq[2*k +: 2]));
    endtask

    task automatic set_all(logic [3:0] r, logic [4*BW-1:0] b);
        for (int g = 0; g < 2; g++) begin
            req[g] = r;
            bin[g] = b;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, elapsed %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        set_all(4'd0, '0);
        for (int g = 0; g < 2; g++) begin
            gcnt[g] = 0;
            pushed[g] = 0;
            popped[g] = 0;
        end
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        check(0, "reset_gnt", 32'(gnt[0]), 32'd0);
        check(0, "reset_bcd", 32'(bcd_out[0]), 32'd0);
        set_all(4'b0010, {8'd0, 8'd0, 8'd255, 8'd0});
        wait_done(0);
        check(0, "t1_bcd", 32'(bcd_out[0]), 32'h255);
        check(0, "t1_id", 32'(done_id[0]), 32'd1);
        @(negedge clk);
        check(0, "t1_gnt_clear", 32'(gnt[0]), 32'd0);
        wait_idle();
        do_reset();
        set_all(4'b1111, {8'd0, 8'd9, 8'd10, 8'd99});
        wait_idle();
        check_order(0, "t2_order", 4, {2'd0, 2'd1, 2'd2, 2'd3});
        check_order(1, "t2_order", 4, {2'd3, 2'd2, 2'd1, 2'd0});
        check(0, "t2_last_bcd", 32'(bcd_out[0]), 32'h099);
        do_reset();
        auto_drop = 4'h0;
        set_all(4'b1111, {8'd0, 8'd9, 8'd10, 8'd99});
        repeat (58) @(negedge clk);
        check_order(0, "t3_order", 6, {4'd0, {6{2'd3}}});
        check_order(1, "t3_order", 6, {4'd0, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0});
        set_all(4'd0, {8'd0, 8'd9, 8'd10, 8'd99});
        repeat (12) @(negedge clk);
        do_reset();
        set_all(4'b1001, {8'd77, 8'd9, 8'd10, 8'd99});
        repeat (45) @(negedge clk);
        check_order(0, "t6_order", 5, {6'd0, {5{2'd3}}});
        check_order(1, "t6_order", 5, {6'd0, 2'd0, 2'd3, 2'd0, 2'd3, 2'd0});
        set_all(4'd0, {8'd77, 8'd9, 8'd10, 8'd99});
        auto_drop = 4'hF;
        repeat (12) @(negedge clk);
        set_all(4'b0100, {8'd0, 8'd137, 8'd0, 8'd0});
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check(0, "t4_gnt", 32'(gnt[0]), 32'd0);
        check(0, "t4_busy", 32'(busy[0]), 32'd0);
        check(0, "t4_done", 32'(done[0]), 32'd0);
        check(0, "t4_bcd", 32'(bcd_out[0]), 32'd0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        wait_done(0);
        check(0, "t4_id", 32'(done_id[0]), 32'd2);
        check(0, "t4_bcd_after", 32'(bcd_out[0]), 32'h137);
        wait_idle();
        set_all(4'b0001, {8'd0, 8'd0, 8'd0, 8'd42});
        @(posedge clk);
        @(posedge clk);
        #1 set_all(4'b0001, {8'd0, 8'd0, 8'd0, 8'd200});
        @(posedge clk);
        @(posedge clk);
        #1 set_all(4'b0000, {8'd0, 8'd0, 8'd0, 8'd200});
        wait_done(0);
        check(0, "t5_bcd", 32'(bcd_out[0]), 32'h042);
        check(0, "t5_id", 32'(done_id[0]), 32'd0);
        check(1, "t5_bcd", 32'(bcd_out[1]), 32'h042);
        repeat (4) @(negedge clk);
        do_reset();
        rand_on = 1'b1;
        repeat (1500) @(negedge clk);
        @(posedge clk);
        #3 reset_n = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (1500) @(negedge clk);
        rand_on = 1'b0;
        #1 set_all(4'd0, '0);
        repeat (15) @(negedge clk);
        check(0, "drained", 32'(pushed[0] - popped[0]), 32'd0);
        check(1, "drained", 32'(pushed[1] - popped[1]), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
